// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the RV32M multiply/divide sequencer.
//   - ALU opcodes understood by the shared 32-bit ALU (ADD, SUB, SLTU)
//   - MDU operation codes as presented on the sequencer 'op' port
//   - sequencer state encoding
//   - two's-complement negate helper used for signed divide fix-ups
package alu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_SLTU = 5'b00111;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULHU = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_REMU  = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_REM   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MUL_STEP  = 3'd1,
    ST_DIV_SHIFT = 3'd2,
    ST_DIV_CMP   = 3'd3,
    ST_DIV_SUB   = 3'd4,
    ST_FIN       = 3'd5
  } state_e;

  // Two's-complement negate (0 - x).
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return (~x) + 32'd1;
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle RV32M MUL/MULHU/DIV/DIVU/REM/REMU sequencer.
// It borrows the shared ALU through alu_req/alu_gnt; each iteration issues at
// most one ALU operation (ADD for shift-add multiply, SLTU/SUB for restoring
// divide). A withheld grant freezes the sequencer with stable ALU operands.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op         request and operation (0 MUL,1 MULHU,2 DIVU,3 REMU,
//                     4 DIV,5 REM; 6/7 behave as MUL), sampled in IDLE only
//   src_a, src_b      multiplicand/dividend, multiplier/divisor
//   flush             abort current op (no done); wins over start
//   busy, done        busy from accept+1 through the done cycle; done pulse
//   result            op result, held between operations
//   alu_req, alu_gnt  shared ALU request / same-cycle grant
//   alu_aluc/a/b      ALU opcode and operands (ADD/0/0 when not requesting)
//   alu_result        combinational ALU output
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [4:0]      alu_aluc,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result
);

  // hi_r/lo_r are the 64-bit product during multiply; during divide hi_r is
  // the partial remainder and lo_r the dividend shifting into the quotient.
  state_e             state_r;
  logic [2:0]         op_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [XLEN-1:0]    hi_r;
  logic [XLEN-1:0]    lo_r;
  logic [XLEN-1:0]    opb_r;
  logic               neg_q_r;
  logic               neg_r_r;

  logic [2:0]         op_norm_s;
  logic               op_is_div_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [XLEN-1:0]    abs_a_s;
  logic [XLEN-1:0]    abs_b_s;
  logic               carry_s;
  logic               last_bit_s;
  logic [XLEN-1:0]    fin_result_s;

  // Decode the incoming request and form operand magnitudes for signed divide.
  always_comb begin
    op_norm_s   = op;
    op_is_div_s = 1'b0;
    a_neg_s     = 1'b0;
    b_neg_s     = 1'b0;
    if (op > OP_REM) begin
      op_norm_s = OP_MUL;
    end else begin
      op_norm_s = op;
    end
    if ((op_norm_s == OP_DIVU) || (op_norm_s == OP_REMU) ||
        (op_norm_s == OP_DIV)  || (op_norm_s == OP_REM)) begin
      op_is_div_s = 1'b1;
    end else begin
      op_is_div_s = 1'b0;
    end
    if ((op_norm_s == OP_DIV) || (op_norm_s == OP_REM)) begin
      a_neg_s = src_a[XLEN-1];
      b_neg_s = src_b[XLEN-1];
    end else begin
      a_neg_s = 1'b0;
      b_neg_s = 1'b0;
    end
    abs_a_s = a_neg_s ? neg32(src_a) : src_a;
    abs_b_s = b_neg_s ? neg32(src_b) : src_b;
  end

  // Iteration helpers: add carry-out recovered from the wrapped sum, last bit.
  always_comb begin
    carry_s    = (alu_result < hi_r);
    last_bit_s = (cnt_r == CNT_W'(XLEN - 1));
  end

  // Final result selection with signed divide/remainder fix-up.
  always_comb begin
    fin_result_s = lo_r;
    case (op_r)
      OP_MUL:   fin_result_s = lo_r;
      OP_MULHU: fin_result_s = hi_r;
      OP_DIVU:  fin_result_s = lo_r;
      OP_REMU:  fin_result_s = hi_r;
      OP_DIV:   fin_result_s = neg_q_r ? neg32(lo_r) : lo_r;
      OP_REM:   fin_result_s = neg_r_r ? neg32(hi_r) : hi_r;
      default:  fin_result_s = lo_r;
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      op_r    <= OP_MUL;
      cnt_r   <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      opb_r   <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state_r <= ST_IDLE;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            busy <= start;
            if (start) begin
              op_r  <= op_norm_s;
              cnt_r <= '0;
              if (op_is_div_s) begin
                if (src_b == '0) begin
                  // Divide by zero: q = all ones, r = original dividend.
                  lo_r    <= '1;
                  hi_r    <= src_a;
                  opb_r   <= '0;
                  neg_q_r <= 1'b0;
                  neg_r_r <= 1'b0;
                  state_r <= ST_FIN;
                end else begin
                  lo_r    <= abs_a_s;
                  hi_r    <= '0;
                  opb_r   <= abs_b_s;
                  neg_q_r <= a_neg_s ^ b_neg_s;
                  neg_r_r <= a_neg_s;
                  state_r <= ST_DIV_SHIFT;
                end
              end else begin
                lo_r    <= src_b;
                hi_r    <= '0;
                opb_r   <= src_a;
                neg_q_r <= 1'b0;
                neg_r_r <= 1'b0;
                state_r <= ST_MUL_STEP;
              end
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_MUL_STEP: begin
            if (lo_r[0] && !alu_gnt) begin
              state_r <= ST_MUL_STEP;
            end else begin
              if (lo_r[0]) begin
                hi_r <= {carry_s, alu_result[XLEN-1:1]};
                lo_r <= {alu_result[0], lo_r[XLEN-1:1]};
              end else begin
                hi_r <= {1'b0, hi_r[XLEN-1:1]};
                lo_r <= {hi_r[0], lo_r[XLEN-1:1]};
              end
              cnt_r   <= cnt_r + CNT_W'(1);
              state_r <= last_bit_s ? ST_FIN : ST_MUL_STEP;
            end
          end
          ST_DIV_SHIFT: begin
            // The bit shifted out of the remainder is the 33rd bit; when set
            // the remainder certainly exceeds the divisor, so skip compare.
            hi_r    <= {hi_r[XLEN-2:0], lo_r[XLEN-1]};
            lo_r    <= {lo_r[XLEN-2:0], 1'b0};
            state_r <= hi_r[XLEN-1] ? ST_DIV_SUB : ST_DIV_CMP;
          end
          ST_DIV_CMP: begin
            if (alu_gnt) begin
              if (alu_result[0]) begin
                cnt_r   <= cnt_r + CNT_W'(1);
                state_r <= last_bit_s ? ST_FIN : ST_DIV_SHIFT;
              end else begin
                state_r <= ST_DIV_SUB;
              end
            end else begin
              state_r <= ST_DIV_CMP;
            end
          end
          ST_DIV_SUB: begin
            if (alu_gnt) begin
              hi_r    <= alu_result;
              lo_r[0] <= 1'b1;
              cnt_r   <= cnt_r + CNT_W'(1);
              state_r <= last_bit_s ? ST_FIN : ST_DIV_SHIFT;
            end else begin
              state_r <= ST_DIV_SUB;
            end
          end
          ST_FIN: begin
            result  <= fin_result_s;
            done    <= 1'b1;
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Shared-ALU request and operands; flush drops the request in the same cycle.
  always_comb begin
    alu_req  = 1'b0;
    alu_aluc = ALU_ADD;
    alu_a    = '0;
    alu_b    = '0;
    if (!flush) begin
      case (state_r)
        ST_MUL_STEP: begin
          if (lo_r[0]) begin
            alu_req  = 1'b1;
            alu_aluc = ALU_ADD;
            alu_a    = hi_r;
            alu_b    = opb_r;
          end else begin
            alu_req  = 1'b0;
          end
        end
        ST_DIV_CMP: begin
          alu_req  = 1'b1;
          alu_aluc = ALU_SLTU;
          alu_a    = hi_r;
          alu_b    = opb_r;
        end
        ST_DIV_SUB: begin
          alu_req  = 1'b1;
          alu_aluc = ALU_SUB;
          alu_a    = hi_r;
          alu_b    = opb_r;
        end
        default: begin
          alu_req  = 1'b0;
        end
      endcase
    end else begin
      alu_req = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: combinational ALU model behind a
// grant source (tied high, random or held low), expected results queued when
// an op is issued and compared when done pulses.
module tb_alu_muldiv_seq;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        alu_req;
  logic        alu_gnt;
  logic [4:0]  alu_aluc;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;

  logic [1:0]  gnt_mode;   // 0 tied high, 1 random, 2 held low
  logic        rnd_gnt;

  int          n_cmp;
  int          n_bad;
  int          done_cnt;
  logic        req_seen;
  logic [31:0] exp_q[$];

  alu_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .flush(flush), .busy(busy), .done(done), .result(result),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_aluc(alu_aluc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign alu_gnt = (gnt_mode == 2'd0) ? 1'b1 :
                   (gnt_mode == 2'd1) ? rnd_gnt : 1'b0;

  // Shared combinational ALU.
  always_comb begin
    case (alu_aluc)
      ALU_ADD:  alu_result = alu_a + alu_b;
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_SLTU: alu_result = {31'd0, (alu_a < alu_b)};
      default:  alu_result = 32'd0;
    endcase
  end

  // Arbiter model: a fresh random grant every cycle.
  initial begin
    rnd_gnt = 1'b1;
    forever begin
      @(negedge clk);
      rnd_gnt = 1'($urandom_range(0, 1));
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    p   = {32'd0, a} * {32'd0, b};
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd1: return p[63:32];
      3'd2: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd3: return (b == 32'd0) ? a : a % b;
      3'd4: return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      3'd5: return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: return p[31:0];
    endcase
  endfunction

  // Scoreboard monitor: every done pops one expected result.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check_val("spurious_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("result", {32'd0, result}, {32'd0, e});
        end
      end
      if (alu_req) req_seen = 1'b1;
    end
  end

  // Issue one op, queue its expected result and return cycles from accept to done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        output int lat);
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!done) check_val("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int budget);
    int k;
    int c0;
    k  = 0;
    c0 = done_cnt;
    while (done_cnt == c0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == c0) check_val("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_busy"},   {63'd0, busy},    64'd0);
    check_val({tag, "_done"},   {63'd0, done},    64'd0);
    check_val({tag, "_result"}, {32'd0, result},  64'd0);
    check_val({tag, "_req"},    {63'd0, alu_req}, 64'd0);
    check_val({tag, "_aluc"},   {59'd0, alu_aluc}, {59'd0, ALU_ADD});
    check_val({tag, "_a"},      {32'd0, alu_a},   64'd0);
    check_val({tag, "_b"},      {32'd0, alu_b},   64'd0);
  endtask

  initial begin
    int          lat;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] hold_a;
    logic [31:0] hold_b;
    logic [4:0]  hold_c;
    logic [31:0] res_before;
    int          c0;

    n_cmp = 0; n_bad = 0; done_cnt = 0; req_seen = 1'b0;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0;
    src_a = 32'd0; src_b = 32'd0; gnt_mode = 2'd0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Multiply corner with exact latency.
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    check_val("mul_latency", 64'(lat), 64'd33);
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, lat);
    check_val("mulhu_latency", 64'(lat), 64'd33);

    // Divide vectors, including the 33rd-bit path and signed overflow.
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, lat);
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, lat);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, lat);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, lat);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, lat);
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, lat);
    run_op(3'd7, 32'd1234, 32'd5678, 32'd7006652, lat);

    // Divide by zero: no ALU traffic at all.
    @(negedge clk); req_seen = 1'b0;
    run_op(OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, lat);
    run_op(OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, lat);
    run_op(OP_REM, 32'hF000_0001, 32'd0, 32'hF000_0001, lat);
    @(negedge clk);
    check_val("div0_no_req", {63'd0, req_seen}, 64'd0);

    // Grant withheld mid-multiply: request and operands must hold.
    @(negedge clk);
    op = OP_MUL; src_a = 32'h1234_5678; src_b = 32'hFFFF_FFFF; start = 1'b1;
    exp_q.push_back(ref_model(OP_MUL, 32'h1234_5678, 32'hFFFF_FFFF));
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    gnt_mode = 2'd2;
    #1;
    hold_a = alu_a; hold_b = alu_b; hold_c = alu_aluc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("hold_req",  {63'd0, alu_req},  64'd1);
      check_val("hold_a",    {32'd0, alu_a},    {32'd0, hold_a});
      check_val("hold_b",    {32'd0, alu_b},    {32'd0, hold_b});
      check_val("hold_aluc", {59'd0, alu_aluc}, {59'd0, hold_c});
    end
    gnt_mode = 2'd0;
    wait_done(100);

    // Flush at iteration 5: no done, result untouched, then a fresh op.
    @(negedge clk);
    res_before = result;
    op = OP_MUL; src_a = 32'hDEAD_BEEF; src_b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    #1 check_val("flush_req_drop", {63'd0, alu_req}, 64'd0);
    @(negedge clk); flush = 1'b0;
    check_val("flush_busy", {63'd0, busy}, 64'd0);
    c0 = done_cnt;
    repeat (40) @(negedge clk);
    check_val("flush_no_done", 64'(done_cnt), 64'(c0));
    check_val("flush_result_held", {32'd0, result}, {32'd0, res_before});
    run_op(OP_DIVU, 32'd1000, 32'd33, 32'd30, lat);

    // Flush together with start in IDLE: flush wins.
    @(negedge clk);
    op = OP_MUL; src_a = 32'd3; src_b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    check_val("flush_start_busy", {63'd0, busy}, 64'd0);

    // Random operations with a random grant.
    gnt_mode = 2'd1;
    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) rb = 32'hFFFF_FFFF;
      run_op(ro, ra, rb, ref_model(ro, ra, rb), lat);
    end
    gnt_mode = 2'd0;

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    op = OP_DIVU; src_a = 32'hFFFF_FFFF; src_b = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midop_reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_op(OP_REMU, 32'd1000, 32'd33, 32'd10, lat);

    repeat (3) @(negedge clk);
    check_val("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
